avalon_rpm_multi: RTL
=====================

# avalon_rpm_multi

Parametrised Avalon-MM slave that exposes the RPM values of `N_CH` motor channels to the Nios/HPS bus. It replaces the single-channel, read-only RPM port. Additions over that port:
- per-channel sign-extended readout
- an atomic freeze/snapshot of all channels, so multi-channel reads are coherent
- per-channel peak-magnitude capture with clear-on-write

It sits between the encoder/RPM estimator blocks and the Avalon interconnect.

## Interface
- `N_CH`, default 4: number of RPM channels; 1..64.
- `RPM_W`, default 16: width of each signed RPM sample; 2..32.
- `ADDR_W`, default 4: word-address width; must satisfy 2^ADDR_W >= 2*N_CH+1.
- `clk` input, 1: system clock. Everything is synchronous to `clk`.
- `reset` input, 1: synchronous, active-high reset.
- `address` input, ADDR_W: word address.
- `read` input, 1: Avalon read strobe.
- `write` input, 1: Avalon write strobe.
- `writedata` input, 32: write data.
- `readdata` output, 32: registered read data.
- `waitrequest` output, 1: Avalon wait-state request.
- `rpm` input, N_CH*RPM_W: packed signed samples. Channel i is at `[i*RPM_W +: RPM_W]`.

## Operation
Register map (word addresses):
- 0..N_CH-1, SNAP[i], RO: `snap[i]` sign-extended to 32 bits.
- N_CH, CTRL, RW:
  - bit0 FREEZE (RW).
  - bit1 SNAP_NOW (write-1 pulse; always reads 0).
  - bits[31:2] read 0.
- N_CH+1..2*N_CH, PEAK[i], RW: `peak[i]` zero-extended. A write of any value clears it.
- Unmapped addresses: read 0; writes are ignored.

Per-channel behaviour, evaluated every cycle:
- Snapshot:
  - FREEZE=0: `snap[i] <= rpm[i]`.
  - FREEZE=1: `snap[i]` holds.
  - A CTRL write with writedata[1]=1 loads `snap[i] <= rpm[i]` for all channels in that cycle, regardless of FREEZE.
  - If that same write also changes FREEZE, the new FREEZE applies from the next cycle.
- Peak:
  - `mag = |rpm[i]|` as unsigned RPM_W bits. The most negative input -2^(RPM_W-1) gives 2^(RPM_W-1), with no overflow.
  - `peak[i] <= max(peak[i], mag)`.
  - On a PEAK[i] write, `peak[i] <= mag`. Clear wins over max, and that cycle's sample is retained.

Read FSM, states IDLE and ACK:
- IDLE & read: readdata is latched from the addressed register, state goes to ACK, and waitrequest=1.
- ACK & read: waitrequest=0 and the transfer completes; state returns to IDLE.
- ACK & !read (read abandoned): state returns to IDLE; no side effects.
- Combinational `waitrequest = read & (state==IDLE)`.

Writes complete in one cycle:
- A write with read low drives waitrequest=0, and the register updates at the next edge.
- If read and write are asserted together, the read is serviced and the write is ignored.

Reset values:
- state IDLE
- readdata 0
- FREEZE 0
- `snap[*]` 0
- `peak[*]` 0

While reset is high, waitrequest still follows the combinational equation, and no register updates except to its reset value.

## Timing
- Read latency: 1 wait state. Address is sampled in cycle 1. readdata is valid in cycle 2, when waitrequest=0. readdata holds until the next read is latched.
- Back-to-back reads take 2 cycles each. A read presented in the cycle after ACK starts again at IDLE.
- Read data reflects register contents at the edge ending cycle 1.
- SNAP readout latency: an `rpm` change at edge k is visible in `snap` after edge k+1. It appears in readdata for a read whose cycle 1 follows that edge.
- A CTRL write at edge k freezes the value sampled at edge k.
- Reset mid-read: the FSM returns to IDLE and any pending read restarts with a wait state.

## Structure
- Package `avalon_rpm_pkg`:
  - FSM state enum {IDLE, ACK}.
  - CTRL bit positions FREEZE_BIT=0 and SNAP_BIT=1.
  - Functions for the SNAP/CTRL/PEAK base offsets as functions of N_CH.
- Sub-module `rpm_channel` (RPM_W): one per channel, via a generate loop.
  - Inputs: `rpm`, `freeze`, `snap_now`, `peak_clr`.
  - Outputs: `snap`, `peak`.
- Top level: address decode, read mux, read FSM and CTRL register.

## Test plan
- Reset, then read SNAP[0] with rpm ch0=16'hFF38 (-200) → waitrequest 1 for one cycle, then readdata=32'hFFFFFF38.
- Write CTRL=1, change rpm ch1 from 1000 to 2000, read SNAP[1] → 1000. Write CTRL=3, read → 2000. Write CTRL=0 → SNAP[1] tracks rpm again.
- Drive ch2 through 300, -900, 500 → PEAK[2]=900. Write PEAK[2] while rpm=-50 → PEAK[2]=50.
- RPM_W=16, ch3=-32768 → PEAK[3]=32'h00008000 and SNAP[3]=32'hFFFF8000.
- Read address 2*N_CH+1 (unmapped) → 0. Assert read and write together to CTRL with data 1 → CTRL read returns 0, write ignored.
- Drop read while in ACK, then assert reset during a read → no state corruption; the next read again shows a single wait state.

Source files
------------

// File: rtl/avalon_rpm_multi_pkg.sv
// Shared types and register-map helpers for the multi-channel RPM Avalon slave.
package avalon_rpm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rd_state_t;

  localparam int FREEZE_BIT = 0;
  localparam int SNAP_BIT   = 1;

  // Word offsets of each register bank for a given channel count.
  function automatic int snap_base(input int n_ch);
    return n_ch * 0;
  endfunction

  function automatic int ctrl_addr(input int n_ch);
    return n_ch;
  endfunction

  function automatic int peak_base(input int n_ch);
    return n_ch + 1;
  endfunction

endpackage

// File: rtl/avalon_rpm_multi_if.sv
// Avalon-MM slave bus bundle used between the interconnect and the RPM register block.
interface avalon_rpm_multi_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_rpm_multi_rpm_channel.sv
// One RPM channel: snapshot register with freeze/force-load, and peak-magnitude tracker.
module rpm_channel #(
  parameter int RPM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RPM_W-1:0] rpm,
  input  logic             freeze,
  input  logic             snap_now,
  input  logic             peak_clr,
  output logic [RPM_W-1:0] snap,
  output logic [RPM_W-1:0] peak
);

  logic [RPM_W-1:0] r_snap;
  logic [RPM_W-1:0] r_peak;
  logic [RPM_W-1:0] w_mag;

  // Unsigned magnitude: the most negative value maps to 2^(RPM_W-1) without wrapping.
  assign w_mag = rpm[RPM_W-1] ? (~rpm + RPM_W'(1)) : rpm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= '0;
      r_peak <= '0;
    end else begin
      if (snap_now || !freeze) begin
        r_snap <= rpm;
      end
      if (peak_clr || (w_mag > r_peak)) begin
        r_peak <= w_mag;
      end
    end
  end

  assign snap = r_snap;
  assign peak = r_peak;

endmodule

// File: rtl/avalon_rpm_multi.sv
// Avalon-MM slave exposing per-channel RPM snapshots, a freeze/snapshot control
// register and clear-on-write peak magnitudes, with a one-wait-state read path.
module avalon_rpm_multi
  import avalon_rpm_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int RPM_W  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_rpm_multi_if.slave     bus,
  input  logic [N_CH*RPM_W-1:0] rpm
);

  rd_state_t         r_state;
  logic [31:0]       r_readdata;
  logic              r_freeze;

  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_addr32;
  logic              w_wr_ok;
  logic              w_ctrl_wr;
  logic              w_snap_now;
  logic [N_CH-1:0]   w_peak_clr;
  logic [RPM_W-1:0]  w_snap [N_CH];
  logic [RPM_W-1:0]  w_peak [N_CH];
  logic [31:0]       w_rd_data;
  logic              w_unused_wdata;

  assign w_addr   = bus.address;
  assign w_addr32 = 32'(w_addr);

  // A simultaneous read takes priority, so the write is dropped entirely.
  assign w_wr_ok        = bus.write && !bus.read;
  assign w_ctrl_wr      = w_wr_ok && (w_addr32 == 32'(ctrl_addr(N_CH)));
  assign w_snap_now     = w_ctrl_wr && bus.writedata[SNAP_BIT];
  assign w_unused_wdata = ^bus.writedata[31:2];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign w_peak_clr[gi] = w_wr_ok && (w_addr32 == 32'(peak_base(N_CH) + gi));

    rpm_channel #(
      .RPM_W (RPM_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .rpm      (rpm[gi*RPM_W +: RPM_W]),
      .freeze   (r_freeze),
      .snap_now (w_snap_now),
      .peak_clr (w_peak_clr[gi]),
      .snap     (w_snap[gi]),
      .peak     (w_peak[gi])
    );
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_addr32 == 32'(snap_base(N_CH) + i)) begin
        w_rd_data = 32'(signed'(w_snap[i]));
      end
      if (w_addr32 == 32'(peak_base(N_CH) + i)) begin
        w_rd_data = 32'(w_peak[i]);
      end
    end
    if (w_addr32 == 32'(ctrl_addr(N_CH))) begin
      w_rd_data[FREEZE_BIT] = r_freeze;
    end
  end

  // New FREEZE value takes effect from the cycle after the CTRL write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_readdata <= '0;
      r_freeze   <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_freeze <= bus.writedata[FREEZE_BIT];
      end
      case (r_state)
        IDLE: begin
          if (bus.read) begin
            r_readdata <= w_rd_data;
            r_state    <= ACK;
          end
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.waitrequest = bus.read && (r_state == IDLE);
  assign bus.readdata    = r_readdata;

endmodule
